// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the trace entry layout, the "no store" byte-enable value and the
// default size of the data-memory window.
package dm_responder_pkg;

    // Byte-enable value meaning "no store this cycle".
    localparam logic [3:0] BYTEEN_NONE = 4'b0000;

    // Default data-memory window: byte addresses below this are in range.
    localparam logic [31:0] DM_RANGE_DEFAULT = 32'h0000_3000;

    // One trace record per accepted store (100 bits).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// trace_fifo: synchronous FIFO for store trace records.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   push, wr_data   - enqueue request and its payload
//   pop             - consumer ready; ignored while empty
//   full            - count == FIFO_DEPTH
//   valid           - registered non-empty flag
//   rd_data         - head entry, zero while empty
// A push while full is only accepted when a pop frees a slot in the same
// cycle; otherwise the entry is dropped and the contents are untouched.
module trace_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] store [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic pop_fire;
    logic push_fire;

    assign full      = (count == CNT_FULL);
    assign pop_fire  = pop && valid;
    // Pop frees a slot first, so push into a full FIFO succeeds with a pop.
    assign push_fire = push && (!full || pop_fire);

    assign rd_data = valid ? store[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10: begin
                    count <= count + 1'b1;
                    valid <= 1'b1;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    valid <= (count != CNT_W'(1));
                end
                default: begin
                end
            endcase
        end
    end

    // Payload storage carries no reset; valid gates what is visible.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            store[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: data-memory slave for the CPU data-side bus.
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   m_data_addr/wdata/byteen   - access address, lane-aligned store data, lane enables
//   m_inst_addr                - PC of the issuing instruction (trace only)
//   m_data_rdata               - combinational read of the addressed word
//   addr_err                   - sticky out-of-range access flag
//   trace_valid/ready          - trace FIFO head handshake
//   trace_pc/addr/wdata/byteen - trace FIFO head entry (zero while empty)
//   trace_overflow             - sticky flag: store arrived with the FIFO full
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = int'(DM_RANGE_DEFAULT >> 2),
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        addr_err,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_wdata,
    output logic [3:0]  trace_byteen,
    output logic        trace_overflow
);

    localparam logic [31:0] DM_LIMIT = 32'(4 * DEPTH_WORDS);

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] index;
    logic              in_range;
    logic              is_store;
    logic              store_ok;
    logic              fifo_full;
    logic              fifo_pop;
    trace_entry_t      push_entry;
    trace_entry_t      head_entry;

    assign index    = m_data_addr[ADDR_W+1:2];
    assign in_range = (m_data_addr < DM_LIMIT);
    assign is_store = (m_data_byteen != BYTEEN_NONE);
    assign store_ok = is_store && in_range;

    // Read returns the pre-edge contents, so a same-cycle store is not seen.
    assign m_data_rdata = in_range ? mem[index] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (m_data_byteen[b]) begin
                    mem[index][8*b +: 8] <= m_data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range idle cycles with PC 0 are pipeline bubbles, not errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err       <= 1'b0;
            trace_overflow <= 1'b0;
        end else begin
            if (!in_range && (is_store || (m_inst_addr != 32'h0))) begin
                addr_err <= 1'b1;
            end
            if (store_ok && fifo_full && !fifo_pop) begin
                trace_overflow <= 1'b1;
            end
        end
    end

    assign push_entry.pc     = m_inst_addr;
    assign push_entry.addr   = {m_data_addr[31:2], 2'b00};
    assign push_entry.wdata  = m_data_wdata;
    assign push_entry.byteen = m_data_byteen;

    assign fifo_pop = trace_ready && trace_valid;

    trace_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (TRACE_W)
    ) u_trace_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (store_ok),
        .wr_data (push_entry),
        .pop     (trace_ready),
        .full    (fifo_full),
        .valid   (trace_valid),
        .rd_data (head_entry)
    );

    assign trace_pc     = head_entry.pc;
    assign trace_addr   = head_entry.addr;
    assign trace_wdata  = head_entry.wdata;
    assign trace_byteen = head_entry.byteen;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: store/readback, byte lanes, trace FIFO
// fill/overflow/drain, range errors and mid-stream reset.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        addr_err;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_wdata;
    logic [3:0]  trace_byteen;
    logic        trace_overflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dm_responder dut (
        .clk            (clk),
        .reset          (reset),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .m_data_rdata   (m_data_rdata),
        .addr_err       (addr_err),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_wdata    (trace_wdata),
        .trace_byteen   (trace_byteen),
        .trace_overflow (trace_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Apply bus inputs and let combinational outputs settle.
    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc, input logic rdy);
        m_data_addr   = addr;
        m_data_wdata  = wdata;
        m_data_byteen = be;
        m_inst_addr   = pc;
        trace_ready   = rdy;
        #1;
    endtask

    // Advance one edge and sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        chk({tag, "_valid"}, 32'(trace_valid), 32'd1);
        chk({tag, "_pc"}, trace_pc, pc);
        chk({tag, "_addr"}, trace_addr, addr);
        chk({tag, "_wdata"}, trace_wdata, wdata);
        chk({tag, "_byteen"}, 32'(trace_byteen), 32'(be));
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("rst_rdata", m_data_rdata, 32'h0);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_overflow", 32'(trace_overflow), 32'd0);
        chk("rst_trace_pc", trace_pc, 32'h0);

        // Full-word store, then readback and trace head.
        drive(32'h10, 32'hAABBCCDD, 4'b1111, 32'h3000, 1'b0);
        chk("st1_same_cycle", m_data_rdata, 32'h0);
        tick();
        drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("st1_rdata", m_data_rdata, 32'hAABBCCDD);
        chk_head("st1_head", 32'h3000, 32'h10, 32'hAABBCCDD, 4'b1111);

        // Upper-half store via unaligned address 0x12.
        drive(32'h12, 32'h1122_0000, 4'b1100, 32'h3004, 1'b0);
        chk("st2_same_cycle", m_data_rdata, 32'hAABBCCDD);
        tick();
        drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("st2_rdata", m_data_rdata, 32'h1122CCDD);
        chk("st2_head_pc_stable", trace_pc, 32'h3000);

        // Drain the two entries.
        drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b1);
        tick();
        chk_head("drain_e1", 32'h3004, 32'h10, 32'h1122_0000, 4'b1100);
        tick();
        chk("drain_empty_valid", 32'(trace_valid), 32'd0);
        chk("drain_empty_pc", trace_pc, 32'h0);

        // Nine stores with no consumer: eight fit, the ninth overflows.
        for (int k = 0; k < 9; k++) begin
            drive(32'h100 + 32'(4*k), 32'hC0DE_0000 + 32'(k), 4'b1111, 32'h4000 + 32'(4*k), 1'b0);
            tick();
            if (k == 7) chk("fill8_overflow", 32'(trace_overflow), 32'd0);
        end
        drive(32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("fill9_overflow", 32'(trace_overflow), 32'd1);
        chk_head("fill9_head", 32'h4000, 32'h100, 32'hC0DE_0000, 4'b1111);
        for (int k = 0; k < 9; k++) begin
            drive(32'h100 + 32'(4*k), 32'h0, 4'b0000, 32'h0, 1'b0);
            chk($sformatf("fill_ram%0d", k), m_data_rdata, 32'hC0DE_0000 + 32'(k));
        end

        // Tenth store while full, with a pop in the same cycle.
        drive(32'h124, 32'hC0DE_0009, 4'b1111, 32'h4024, 1'b1);
        tick();
        chk("st10_overflow", 32'(trace_overflow), 32'd1);
        // Remaining contents: stores 1..7 then store 9 (store 8 was dropped).
        drive(32'h124, 32'h0, 4'b0000, 32'h0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            chk_head($sformatf("pop_e%0d", k), 32'h4000 + 32'(4*k), 32'h100 + 32'(4*k),
                     32'hC0DE_0000 + 32'(k), 4'b1111);
            tick();
        end
        chk_head("pop_e9", 32'h4024, 32'h124, 32'hC0DE_0009, 4'b1111);
        chk("st10_ram", m_data_rdata, 32'hC0DE_0009);
        tick();
        chk("pop_done_valid", 32'(trace_valid), 32'd0);

        // Out-of-range idle bubble (PC 0) must not flag.
        drive(32'h4000, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("oor_rdata", m_data_rdata, 32'h0);
        tick();
        chk("bubble_addr_err", 32'(addr_err), 32'd0);

        // Highest in-range word, lowest lane.
        drive(32'h2FFC, 32'h0000_00EE, 4'b0001, 32'h5000, 1'b0);
        tick();
        drive(32'h2FFC, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("top_word_rdata", m_data_rdata, 32'h0000_00EE);
        chk("top_word_addr_err", 32'(addr_err), 32'd0);
        chk_head("top_word_head", 32'h5000, 32'h2FFC, 32'h0000_00EE, 4'b0001);
        drive(32'h2FFC, 32'h0, 4'b0000, 32'h0, 1'b1);
        tick();

        // First out-of-range byte address: dropped, no trace, flag set.
        drive(32'h3000, 32'h0000_0077, 4'b0001, 32'h5004, 1'b0);
        tick();
        drive(32'h3000, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("oor_st_addr_err", 32'(addr_err), 32'd1);
        chk("oor_st_valid", 32'(trace_valid), 32'd0);
        chk("oor_st_rdata", m_data_rdata, 32'h0);
        drive(32'h2FFC, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("oor_st_neighbor", m_data_rdata, 32'h0000_00EE);

        // Queue five entries, then reset together with a store.
        for (int k = 0; k < 5; k++) begin
            drive(32'h200 + 32'(4*k), 32'h5A5A_0000 + 32'(k), 4'b1111, 32'h6000 + 32'(4*k), 1'b0);
            tick();
        end
        chk("pre_rst_valid", 32'(trace_valid), 32'd1);
        drive(32'h200, 32'hDEAD_BEEF, 4'b1111, 32'h6100, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(32'h200, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("mid_rst_valid", 32'(trace_valid), 32'd0);
        chk("mid_rst_addr_err", 32'(addr_err), 32'd0);
        chk("mid_rst_overflow", 32'(trace_overflow), 32'd0);
        chk("mid_rst_rdata", m_data_rdata, 32'h0);
        chk("mid_rst_trace_wdata", trace_wdata, 32'h0);
        drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("mid_rst_old_word", m_data_rdata, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
